imem_boot_ctrl: RTL and testbench
=================================

// Module: imem_boot_ctrl
// PURPOSE
//   Boot/program-load controller for the rv32i core. It owns the instruction BRAM write port
//   (i_w_*), the fetch read enable, pc_stall and a core reset hold.
//   It streams a host image into instruction memory through a valid/ready interface, then
//   releases the core to run from PC reset. It can halt the core and reload without a global reset.
// PARAMETERS
//   DEPTH_WORDS  1024  instruction BRAM depth in 32-bit words; bounds base+count check
//   CNT_WIDTH    16    width of word_count and of the internal beat counter
// PORTS
//   clk           in   1          core clock; all logic on rising edge
//   rst           in   1          asynchronous, active-high reset
//   start         in   1          1-cycle pulse: begin load (or direct run if word_count==0)
//   halt          in   1          1-cycle pulse: stop the core and return to HALT
//   base_addr     in   32         byte address of the first word; must be word-aligned
//   word_count    in   CNT_WIDTH  number of 32-bit words to load; sampled when start is accepted
//   s_valid       in   1          host data beat valid
//   s_data        in   32         host data word (little-endian instruction word)
//   s_ready       out  1          controller accepts a beat this cycle
//   i_w_addr      out  32         instruction BRAM byte write address (word-aligned)
//   i_w_dat       out  32         instruction BRAM write data
//   i_w_enb       out  1          instruction BRAM write enable
//   i_w_byte_enb  out  4          byte enables; 4'hF whenever i_w_enb=1, else 4'h0
//   i_r_enb       out  1          fetch read enable for instruction BRAM
//   pc_stall      out  1          holds the PC
//   core_rst      out  1          reset to PC/regfile while not running
//   busy          out  1          high in LOAD or DRAIN
//   done          out  1          1-cycle pulse on entering RUN
//   err           out  1          sticky; cleared by the next accepted start
// BEHAVIOUR
//   Reset values: state=HALT, s_ready=0, i_w_enb=0, i_w_addr=0, i_w_dat=0, i_w_byte_enb=0,
//     i_r_enb=0, pc_stall=1, core_rst=1, busy=0, done=0, err=0, counter=0.
//   Output decode (registered outputs, driven from the state register):
//     HALT  -> pc_stall=1, core_rst=1, i_r_enb=0
//     LOAD  -> as HALT; s_ready=1
//     DRAIN -> as HALT; s_ready=0
//     RUN   -> pc_stall=0, core_rst=0, i_r_enb=1
//   HALT transitions:
//     start & misaligned base_addr[1:0]!=0 -> err=1, stay in HALT
//     start & (base_addr>>2)+word_count > DEPTH_WORDS -> err=1, stay in HALT
//     start & word_count==0 -> RUN (boot the resident image); done pulses
//     start & otherwise -> LOAD; latch addr=base_addr, remaining=word_count; clear err
//   LOAD:
//     Beat accepted when s_valid & s_ready.
//     On each beat, the next cycle has i_w_enb=1, i_w_addr=addr, i_w_dat=s_data; then addr+=4, remaining-=1.
//     Write latency is 1 cycle from beat to BRAM write. One beat per cycle, with no bubbles required.
//     The beat that makes remaining==0 moves the FSM to DRAIN; s_ready drops in the same cycle it moves.
//   DRAIN: one cycle so that the final write lands, then RUN with a done pulse.
//     core_rst deasserts on entering RUN, so the first fetch is from PC reset address 0.
//   RUN: halt -> HALT next cycle; start is ignored.
//   Simultaneous events: start ignored outside HALT; halt ignored outside RUN.
//     halt and start in the same cycle: halt wins in RUN, start wins in HALT.
//   Wrap-around: address never wraps, because the bounds check rejects any overrun before LOAD.
//   s_valid with s_ready=0: the beat is not consumed; the host must hold it (standard valid/ready).
//   Reset mid-load: the async rst returns all outputs to reset values immediately.
//     Partially written BRAM contents are not cleared. The host must restart the load.
// STRUCTURE
//   State encodings BOOT_HALT/BOOT_LOAD/BOOT_DRAIN/BOOT_RUN (2-bit) go in rv32i_control.vh.
//   IMEM_DEPTH_WORDS and IMEM_BYTE_ENB_ALL (4'hF) go in rv32i_params.vh.
//   No sub-module: a single FSM + address register + beat counter + one write-staging register.
//   Integration into riscv_cpu:
//     i_w_* connect to I_MEM; i_r_enb connects to I_MEM r_enb; pc_stall connects to PC.stall.
//     core_rst is ORed with rst into PC and REGFILE.
// TESTING
//   1. Reset, then start base=0x0 count=4, 4 beats back-to-back 0x00500093.. -> writes at
//      0x0,0x4,0x8,0xC, each 1 cycle after its beat; DRAIN 1 cycle; done pulse; pc_stall=0.
//   2. Load count=3 with s_valid toggling 1,0,1,0,1 -> exactly 3 writes, no duplicates;
//      i_w_enb=0 on idle cycles.
//   3. start base=0x2 -> err=1, state stays HALT, s_ready=0.
//      start base=0xFFC count=2 (DEPTH=1024) -> err=1.
//      Then a valid start clears err.
//   4. start count=0 -> RUN next cycle with done=1 and no writes; then halt -> pc_stall=1 and
//      core_rst=1 next cycle.
//   5. Assert rst after 2 of 5 beats -> all outputs return to reset values the same cycle;
//      after release, a new start count=5 completes normally.
//   6. In LOAD, pulse start and halt -> both ignored; the load completes with the original
//      base and count.

Source files
------------

// File: rtl/imem_boot_ctrl_pkg.sv
// Shared types and constants for the instruction-memory boot controller.
// Holds boot FSM state encodings and IMEM geometry.
package imem_boot_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT_HALT  = 2'd0,
    BOOT_LOAD  = 2'd1,
    BOOT_DRAIN = 2'd2,
    BOOT_RUN   = 2'd3
  } boot_state_t;

  localparam int         IMEM_DEPTH_WORDS  = 1024;
  localparam logic [3:0] IMEM_BYTE_ENB_ALL = 4'hF;

  // Word index one past the last word of a load.
  function automatic logic [32:0] load_end(
    input logic [31:0] base,
    input logic [31:0] count
  );
    return {3'b000, base[31:2]} + {1'b0, count};
  endfunction

endpackage

// File: rtl/imem_boot_ctrl.sv
// Boot/program-load controller: streams a host image into IMEM,
// then releases the core from reset to run from PC 0.
module imem_boot_ctrl
  import imem_boot_ctrl_pkg::*;
#(
  parameter int DEPTH_WORDS = IMEM_DEPTH_WORDS,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 halt,
  input  logic [31:0]          base_addr,
  input  logic [CNT_WIDTH-1:0] word_count,
  input  logic                 s_valid,
  input  logic [31:0]          s_data,
  output logic                 s_ready,
  output logic [31:0]          i_w_addr,
  output logic [31:0]          i_w_dat,
  output logic                 i_w_enb,
  output logic [3:0]           i_w_byte_enb,
  output logic                 i_r_enb,
  output logic                 pc_stall,
  output logic                 core_rst,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  boot_state_t          state;
  logic [31:0]          addr;
  logic [CNT_WIDTH-1:0] remaining;

  logic misaligned;
  logic overrun;
  logic beat;

  assign misaligned = |base_addr[1:0];
  assign overrun    = load_end(base_addr, 32'(word_count))
                      > 33'(DEPTH_WORDS);
  assign beat       = s_valid & s_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= BOOT_HALT;
      addr         <= '0;
      remaining    <= '0;
      s_ready      <= 1'b0;
      i_w_addr     <= '0;
      i_w_dat      <= '0;
      i_w_enb      <= 1'b0;
      i_w_byte_enb <= 4'h0;
      i_r_enb      <= 1'b0;
      pc_stall     <= 1'b1;
      core_rst     <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      i_w_enb      <= 1'b0;
      i_w_byte_enb <= 4'h0;
      done         <= 1'b0;
      unique case (state)
        BOOT_HALT: begin
          if (start) begin
            if (misaligned || overrun) begin
              err <= 1'b1;
            end else if (word_count == '0) begin
              // Empty load boots whatever image is resident.
              state    <= BOOT_RUN;
              err      <= 1'b0;
              done     <= 1'b1;
              pc_stall <= 1'b0;
              core_rst <= 1'b0;
              i_r_enb  <= 1'b1;
            end else begin
              state     <= BOOT_LOAD;
              addr      <= base_addr;
              remaining <= word_count;
              err       <= 1'b0;
              s_ready   <= 1'b1;
              busy      <= 1'b1;
            end
          end
        end
        BOOT_LOAD: begin
          if (beat) begin
            i_w_enb      <= 1'b1;
            i_w_byte_enb <= IMEM_BYTE_ENB_ALL;
            i_w_addr     <= addr;
            i_w_dat      <= s_data;
            addr         <= addr + 32'd4;
            remaining    <= remaining - CNT_WIDTH'(1);
            if (remaining == CNT_WIDTH'(1)) begin
              state   <= BOOT_DRAIN;
              s_ready <= 1'b0;
            end
          end
        end
        BOOT_DRAIN: begin
          state    <= BOOT_RUN;
          busy     <= 1'b0;
          done     <= 1'b1;
          pc_stall <= 1'b0;
          core_rst <= 1'b0;
          i_r_enb  <= 1'b1;
        end
        BOOT_RUN: begin
          if (halt) begin
            state    <= BOOT_HALT;
            pc_stall <= 1'b1;
            core_rst <= 1'b1;
            i_r_enb  <= 1'b0;
          end
        end
        default: state <= BOOT_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Scoreboard bench for imem_boot_ctrl: a negedge reference model
// predicts writes/done pulses; a posedge monitor pops and compares.
module tb_imem_boot_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        halt = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] word_count = '0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_ready;
  logic [31:0] i_w_addr;
  logic [31:0] i_w_dat;
  logic        i_w_enb;
  logic [3:0]  i_w_byte_enb;
  logic        i_r_enb;
  logic        pc_stall;
  logic        core_rst;
  logic        busy;
  logic        done;
  logic        err;

  imem_boot_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt),
    .base_addr(base_addr), .word_count(word_count),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .i_w_addr(i_w_addr), .i_w_dat(i_w_dat), .i_w_enb(i_w_enb),
    .i_w_byte_enb(i_w_byte_enb), .i_r_enb(i_r_enb),
    .pc_stall(pc_stall), .core_rst(core_rst), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference model: abstract phases of a boot session.
  typedef enum {M_IDLE, M_LOAD, M_DRAIN, M_RUN} mode_t;
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    int          c;
  } wr_t;

  wr_t         wq[$];
  int          dq[$];
  mode_t       mode = M_IDLE;
  bit          merr = 1'b0;
  logic [31:0] maddr = '0;
  int          mrem = 0;

  always @(negedge clk) begin
    if (rst) begin
      mode = M_IDLE;
      merr = 1'b0;
      wq.delete();
      dq.delete();
    end else begin
      chk("s_ready", 32'(s_ready), 32'(mode == M_LOAD));
      chk("pc_stall", 32'(pc_stall), 32'(mode != M_RUN));
      chk("core_rst", 32'(core_rst), 32'(mode != M_RUN));
      chk("i_r_enb", 32'(i_r_enb), 32'(mode == M_RUN));
      chk("busy", 32'(busy),
          32'(mode == M_LOAD || mode == M_DRAIN));
      chk("err", 32'(err), 32'(merr));
      chk("byte_enb", 32'(i_w_byte_enb),
          i_w_enb ? 32'hF : 32'h0);
      case (mode)
        M_IDLE: if (start) begin
          if (base_addr[1:0] != 2'b00 ||
              longint'(base_addr / 4) + longint'(word_count) > 1024)
            merr = 1'b1;
          else if (word_count == 0) begin
            merr = 1'b0;
            mode = M_RUN;
            dq.push_back(cyc + 1);
          end else begin
            merr  = 1'b0;
            mode  = M_LOAD;
            maddr = base_addr;
            mrem  = int'(word_count);
          end
        end
        M_LOAD: if (s_valid) begin
          wq.push_back('{a: maddr, d: s_data, c: cyc + 1});
          maddr += 4;
          mrem--;
          if (mrem == 0) mode = M_DRAIN;
        end
        M_DRAIN: begin
          mode = M_RUN;
          dq.push_back(cyc + 1);
        end
        M_RUN: if (halt) mode = M_IDLE;
        default: mode = M_IDLE;
      endcase
    end
  end

  // Monitor: every write or done pulse must match the next prediction.
  always @(posedge clk) begin
    wr_t w;
    int  dc;
    #1;
    if (!rst) begin
      if (i_w_enb) begin
        if (wq.size() == 0) flag("unexpected_write");
        else begin
          w = wq.pop_front();
          chk("w_addr", i_w_addr, w.a);
          chk("w_dat", i_w_dat, w.d);
          chk("w_cycle", 32'(cyc), 32'(w.c));
        end
      end
      if (done) begin
        if (dq.size() == 0) flag("unexpected_done");
        else begin
          dc = dq.pop_front();
          chk("done_cycle", 32'(cyc), 32'(dc));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_w_enb", 32'(i_w_enb), 0);
    chk("rst_w_addr", i_w_addr, 0);
    chk("rst_w_dat", i_w_dat, 0);
    chk("rst_byte_enb", 32'(i_w_byte_enb), 0);
    chk("rst_r_enb", 32'(i_r_enb), 0);
    chk("rst_pc_stall", 32'(pc_stall), 1);
    chk("rst_core_rst", 32'(core_rst), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
  endtask

  task automatic pulse_start(input logic [31:0] b,
                             input logic [15:0] c);
    base_addr  = b;
    word_count = c;
    start      = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Load an image; prob = % of cycles with s_valid, toggle forces 1,0,1..
  task automatic run_load(input logic [31:0] b, input logic [15:0] c,
                          input int prob, input bit toggle,
                          input bit seq, input bit inject);
    int n = 0;
    int m = 0;
    pulse_start(b, c);
    while (mode == M_LOAD && n < 300) begin
      s_valid = toggle ? (n % 2 == 0)
                       : (int'($urandom_range(99)) < prob);
      s_data  = seq ? 32'h00500093 + (32'(n) << 20) : $urandom;
      if (inject && n == 1) begin
        start      = 1'b1;
        halt       = 1'b1;
        base_addr  = 32'h40;
        word_count = 16'd7;
      end else begin
        start = 1'b0;
        halt  = 1'b0;
      end
      tick();
      n++;
    end
    s_valid = 1'b0;
    start   = 1'b0;
    halt    = 1'b0;
    if (n >= 300) flag("load_timeout");
    while (mode == M_DRAIN && m < 10) begin
      tick();
      m++;
    end
    if (mode == M_RUN) begin
      repeat (2) tick();
      start = 1'b1;
      tick();
      halt = 1'b1;
      tick();
      start = 1'b0;
      halt  = 1'b0;
      repeat (2) tick();
    end else begin
      repeat (2) tick();
    end
  endtask

  initial begin
    tick();
    check_reset_outputs();
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();

    run_load(32'h0, 16'd4, 100, 1'b0, 1'b1, 1'b0);
    run_load(32'h200, 16'd3, 0, 1'b1, 1'b0, 1'b0);

    pulse_start(32'h2, 16'd5);
    tick();
    pulse_start(32'hFFC, 16'd2);
    tick();
    run_load(32'h100, 16'd2, 100, 1'b0, 1'b0, 1'b0);
    run_load(32'hFF8, 16'd2, 70, 1'b0, 1'b0, 1'b0);

    run_load(32'h80, 16'd0, 100, 1'b0, 1'b0, 1'b0);

    pulse_start(32'h0, 16'd5);
    s_valid = 1'b1;
    repeat (2) begin
      s_data = $urandom;
      tick();
    end
    s_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs();
    repeat (2) tick();
    rst = 1'b0;
    tick();
    run_load(32'h0, 16'd5, 100, 1'b0, 1'b0, 1'b0);

    run_load(32'h300, 16'd4, 100, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 12; i++) begin
      logic [31:0] b;
      b = 32'($urandom_range(1100)) << 2;
      if ($urandom_range(3) == 0) b[1:0] = 2'($urandom_range(1, 3));
      run_load(b, 16'($urandom_range(8)), 60, 1'b0, 1'b0,
               1'($urandom_range(1)));
    end

    repeat (3) tick();
    chk("writes_outstanding", 32'(wq.size()), 0);
    chk("dones_outstanding", 32'(dq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
